pipe_stage_em: RTL and testbench
================================

PIPE_STAGE_EM -- requirements
Module: pipe_stage_em

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of ALUOut and WriteData payload.
REQ-002 SHALL have parameter REGW, default 5: width of destination register index.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port FlushM  input  1  synchronous flush; discards all held beats.
REQ-006 SHALL have ports ValidE input 1 and ReadyE output 1  upstream handshake.
REQ-007 SHALL have ports RegWriteE, MemtoRegE, MemWriteE  input  1 each  EX control bits.
REQ-008 SHALL have ports ALUOutE, WriteDataE input WIDTH and WriteRegE input REGW  EX payload.
REQ-009 SHALL have ports ValidM output 1 and ReadyM input 1  downstream handshake.
REQ-010 SHALL have ports RegWriteM, MemtoRegM, MemWriteM output 1, ALUOutM, WriteDataM output WIDTH, WriteRegM output REGW  MEM-side copies.

Function
REQ-011 SHALL accept a beat when ValidE&&ReadyE at a rising edge, and retire the head beat when ValidM&&ReadyM.
REQ-012 SHALL deliver beats to the MEM side in acceptance order; no beat duplicated or dropped except by FlushM.
REQ-013 SHALL present an accepted beat on the M outputs with ValidM=1 one cycle after acceptance when the stage was empty (latency 1).
REQ-014 SHALL hold all M outputs stable while ValidM=1 and ReadyM=0.
REQ-015 SHALL force RegWriteM, MemtoRegM, MemWriteM to 0 whenever ValidM=0 (bubble); ALUOutM, WriteDataM, WriteRegM are don't-care when ValidM=0.
REQ-016 SHALL hold up to two beats: main register (drives M outputs) and skid register.
REQ-017 State: EMPTY (none held), ONE (main valid), TWO (main and skid valid).
REQ-018 EMPTY: accept -> ONE; else stay.
REQ-019 ONE: accept without retire -> TWO (beat into skid); retire without accept -> EMPTY; both -> ONE with new beat in main; neither -> stay.
REQ-020 TWO: retire -> ONE with skid beat moved to main; else stay; no accept possible.
REQ-021 SHALL drive ReadyE as a registered signal equal to 1 in EMPTY and ONE, 0 in TWO (no combinational path ReadyM->ReadyE).
REQ-022 FlushM=1 at a rising edge SHALL move to EMPTY regardless of ValidE, ReadyM; a beat offered in that cycle is discarded even if ReadyE=1.
REQ-023 ValidE with ReadyE=0 SHALL leave state unchanged; upstream holds the beat.

Reset
REQ-024 On rst_n=0, SHALL immediately enter EMPTY: ValidM=0, RegWriteM=MemtoRegM=MemWriteM=0, ALUOutM=WriteDataM=0, WriteRegM=0, skid cleared, ReadyE=0.
REQ-025 SHALL assert ReadyE=1 at the first rising edge after rst_n deasserts; reset mid-transfer discards all held beats.

Configuration
REQ-026 With macro PIPE_STAGE_EM_SKID_EN defined, SHALL implement REQ-016..REQ-021 (two-entry elastic stage).
REQ-027 Without PIPE_STAGE_EM_SKID_EN, SHALL have no skid register and no TWO state; ReadyE SHALL be combinational ReadyM||!ValidM (0 during reset); all other requirements apply.

Verification
REQ-028 Reset then single beat ALUOutE=0x0000_1234, RegWriteE=1, ReadyM=1 -> next cycle ValidM=1, ALUOutM=0x0000_1234, RegWriteM=1; following cycle ValidM=0, RegWriteM=0.
REQ-029 SKID_EN, ReadyM=0, beats A=0x11, B=0x22 back-to-back -> state TWO, ReadyE=0, ALUOutM=0x11 held; ReadyM=1 for 2 cycles -> outputs 0x11 then 0x22, ReadyE returns to 1.
REQ-030 Random ValidE/ReadyM for 1000 cycles, incrementing payload -> scoreboard sees strictly increasing sequence, no gap, no repeat.
REQ-031 State TWO, FlushM=1 with ValidE=1 payload 0x33 -> next cycle ValidM=0, RegWriteM=MemWriteM=0, ReadyE=1; 0x33 never appears.
REQ-032 rst_n pulsed low mid-cycle with ValidM=1, MemWriteE=1 -> MemWriteM=0 and ValidM=0 immediately, before next clk edge.
REQ-033 Without SKID_EN, ValidM=1, ReadyM=0 -> ReadyE=0 same cycle; ReadyM=1 -> ReadyE=1 same cycle and back-to-back beats stream at one per cycle.

Source files
------------

// File: rtl/pipe_stage_em.sv
// EX->MEM pipeline register carrying control bits and payload with valid/ready handshakes; build option PIPE_STAGE_EM_SKID_EN.
// Latency: 1 cycle from acceptance to ValidM when the stage is empty.
// Backpressure: SKID_EN gives two entries with registered ReadyE, otherwise one entry with ReadyE = ReadyM || !ValidM.
module pipe_stage_em #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             FlushM,
    input  logic             ValidE,
    output logic             ReadyE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MemWriteE,
    input  logic [WIDTH-1:0] ALUOutE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic [REGW-1:0]  WriteRegE,
    output logic             ValidM,
    input  logic             ReadyM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [REGW-1:0]  WriteRegM
);

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic [WIDTH-1:0] aluout;
        logic [WIDTH-1:0] writedata;
        logic [REGW-1:0]  writereg;
    } beat_t;

    // A bubble keeps the payload but must never carry live control bits.
    function automatic beat_t bubble(input beat_t b);
        beat_t r;
        r          = b;
        r.regwrite = 1'b0;
        r.memtoreg = 1'b0;
        r.memwrite = 1'b0;
        return r;
    endfunction

    beat_t w_in;
    beat_t r_main;
    logic  w_acc;
    logic  w_ret;

    assign w_in = {RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE};
    assign {RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM} = r_main;

`ifdef PIPE_STAGE_EM_SKID_EN

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t r_state;
    beat_t  r_skid;
    logic   r_ready_e;

    assign ValidM = (r_state != S_EMPTY);
    assign ReadyE = r_ready_e;
    assign w_acc  = ValidE && r_ready_e;
    assign w_ret  = ValidM && ReadyM;

    // Occupancy FSM: main drives the outputs, skid catches the beat that arrives while main stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_main    <= '0;
            r_skid    <= '0;
            r_ready_e <= 1'b0;
        end else if (FlushM) begin
            r_state   <= S_EMPTY;
            r_main    <= bubble(r_main);
            r_skid    <= '0;
            r_ready_e <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_ready_e <= 1'b1;
                    if (w_acc) begin
                        r_state <= S_ONE;
                        r_main  <= w_in;
                    end
                end
                S_ONE: begin
                    r_ready_e <= !(w_acc && !w_ret);
                    if (w_acc && !w_ret) begin
                        r_state <= S_TWO;
                        r_skid  <= w_in;
                    end else if (w_ret && !w_acc) begin
                        r_state <= S_EMPTY;
                        r_main  <= bubble(r_main);
                    end else if (w_acc && w_ret) begin
                        r_main  <= w_in;
                    end
                end
                S_TWO: begin
                    if (w_ret) begin
                        r_state   <= S_ONE;
                        r_main    <= r_skid;
                        r_ready_e <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_EMPTY;
                    r_main    <= bubble(r_main);
                    r_ready_e <= 1'b1;
                end
            endcase
        end
    end

`else

    logic r_valid;
    logic r_rst_done;

    // ReadyE stays low until the first edge after reset release.
    assign ValidM = r_valid;
    assign ReadyE = r_rst_done && (ReadyM || !r_valid);
    assign w_acc  = ValidE && ReadyE;
    assign w_ret  = r_valid && ReadyM;

    // Single-entry register: load on accept, drop to bubble on retire or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_main     <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (FlushM) begin
                r_valid <= 1'b0;
                r_main  <= bubble(r_main);
            end else if (w_acc) begin
                r_valid <= 1'b1;
                r_main  <= w_in;
            end else if (w_ret) begin
                r_valid <= 1'b0;
                r_main  <= bubble(r_main);
            end
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_em.sv
// Bench for pipe_stage_em: vector table, reset/flush sequences and a random stream checked by a scoreboard.
// Works for both builds; vector expectations follow PIPE_STAGE_EM_SKID_EN.
// Inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
module tb_pipe_stage_em;
    localparam int WIDTH = 32;
    localparam int REGW  = 5;

    logic             clk = 1'b0;
    logic             rst_n, FlushM, ValidE, ReadyE, ReadyM, ValidM;
    logic             RegWriteE, MemtoRegE, MemWriteE, RegWriteM, MemtoRegM, MemWriteM;
    logic [WIDTH-1:0] ALUOutE, WriteDataE, ALUOutM, WriteDataM;
    logic [REGW-1:0]  WriteRegE, WriteRegM;

    always #5 clk = ~clk;

    pipe_stage_em #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n), .FlushM(FlushM),
        .ValidE(ValidE), .ReadyE(ReadyE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
        .ValidM(ValidM), .ReadyM(ReadyM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
    );

    typedef struct packed {
        logic        rw, m2r, mw;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
    } beat_t;

    typedef struct {
        logic        flush, ve, rm;
        logic [31:0] alu;
        logic        rw, mw;
        logic        vm, re;
        logic [31:0] alu_m;
        logic        rw_m, mw_m;
    } vec_t;

    vec_t  vecs[$];
    beat_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  mon_en = 1'b0;
    logic  acc_flag = 1'b0;
    logic  prev_hold = 1'b0;
    beat_t snap;
    beat_t w_out, w_inb;

    assign w_out = {RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM};
    assign w_inb = {RegWriteE, MemtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE};

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic rw, input logic mw);
        ALUOutE    = alu;
        WriteDataE = ~alu;
        WriteRegE  = alu[4:0];
        RegWriteE  = rw;
        MemtoRegE  = alu[1];
        MemWriteE  = mw;
    endtask

    task automatic add(input logic f, input logic ve, input logic rm, input logic [31:0] alu,
                       input logic rw, input logic mw, input logic vm, input logic re,
                       input logic [31:0] alu_m, input logic rw_m, input logic mw_m);
        vec_t v;
        v.flush = f; v.ve = ve; v.rm = rm; v.alu = alu; v.rw = rw; v.mw = mw;
        v.vm = vm; v.re = re; v.alu_m = alu_m; v.rw_m = rw_m; v.mw_m = mw_m;
        vecs.push_back(v);
    endtask

    // Scoreboard monitor: pop on retire, push on accept, plus bubble and stall-hold checks.
    always @(negedge clk) begin
        acc_flag = ValidE && ReadyE && !FlushM && rst_n;
        if (mon_en && rst_n) begin
            if (!ValidM)
                chk("bubble_ctrl", {RegWriteM, MemtoRegM, MemWriteM}, 3'b000);
            if (prev_hold)
                chk("hold_stable", w_out, snap);
            if (ValidM && ReadyM) begin
                if (sb.size() == 0) chk("unexpected_beat", ValidM, 1'b0);
                else chk("sb_beat", w_out, sb.pop_front());
            end
            if (FlushM) sb.delete();
            else if (ValidE && ReadyE) sb.push_back(w_inb);
            prev_hold = ValidM && !ReadyM && !FlushM;
            snap = w_out;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        logic [31:0] seq;
        logic        pending;
        //   f  ve rm alu          rw mw | vm re alu_m        rw mw
`ifdef PIPE_STAGE_EM_SKID_EN
        add(0, 1, 1, 32'h0000_1234, 1, 0,  0, 1, 32'h0,         0, 0);
        add(0, 0, 1, 32'h0,         0, 0,  1, 1, 32'h0000_1234, 1, 0);
        add(0, 0, 1, 32'h0,         0, 0,  0, 1, 32'h0,         0, 0);
        add(0, 1, 0, 32'h11,        0, 0,  0, 1, 32'h0,         0, 0);
        add(0, 1, 0, 32'h22,        1, 1,  1, 1, 32'h11,        0, 0);
        add(0, 1, 0, 32'h2A,        0, 0,  1, 0, 32'h11,        0, 0);
        add(0, 0, 1, 32'h0,         0, 0,  1, 0, 32'h11,        0, 0);
        add(0, 0, 1, 32'h0,         0, 0,  1, 1, 32'h22,        1, 1);
        add(0, 0, 0, 32'h0,         0, 0,  0, 1, 32'h0,         0, 0);
        add(0, 1, 0, 32'h44,        1, 0,  0, 1, 32'h0,         0, 0);
        add(0, 1, 0, 32'h55,        0, 1,  1, 1, 32'h44,        1, 0);
        add(1, 1, 0, 32'h33,        1, 1,  1, 0, 32'h44,        1, 0);
        add(0, 0, 0, 32'h0,         0, 0,  0, 1, 32'h0,         0, 0);
        add(1, 1, 1, 32'h66,        1, 1,  0, 1, 32'h0,         0, 0);
        add(0, 0, 1, 32'h0,         0, 0,  0, 1, 32'h0,         0, 0);
`else
        add(0, 1, 1, 32'h0000_1234, 1, 0,  0, 1, 32'h0,         0, 0);
        add(0, 0, 1, 32'h0,         0, 0,  1, 1, 32'h0000_1234, 1, 0);
        add(0, 0, 1, 32'h0,         0, 0,  0, 1, 32'h0,         0, 0);
        add(0, 1, 0, 32'hA,         0, 1,  0, 1, 32'h0,         0, 0);
        add(0, 1, 0, 32'hB,         1, 0,  1, 0, 32'hA,         0, 1);
        add(0, 1, 0, 32'hB,         1, 0,  1, 0, 32'hA,         0, 1);
        add(0, 1, 1, 32'hB,         1, 0,  1, 1, 32'hA,         0, 1);
        add(0, 1, 1, 32'hC,         0, 1,  1, 1, 32'hB,         1, 0);
        add(0, 0, 1, 32'h0,         0, 0,  1, 1, 32'hC,         0, 1);
        add(0, 0, 0, 32'h0,         0, 0,  0, 1, 32'h0,         0, 0);
        add(0, 1, 0, 32'hD,         1, 1,  0, 1, 32'h0,         0, 0);
        add(1, 0, 0, 32'h0,         0, 0,  1, 0, 32'hD,         1, 1);
        add(1, 1, 1, 32'h33,        1, 1,  0, 1, 32'h0,         0, 0);
        add(0, 0, 0, 32'h0,         0, 0,  0, 1, 32'h0,         0, 0);
`endif

        // Reset state
        rst_n = 1'b0; FlushM = 1'b0; ValidE = 1'b0; ReadyM = 1'b0;
        drive(32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_ValidM", ValidM, 1'b0);
        chk("rst_ReadyE", ReadyE, 1'b0);
        chk("rst_ctrl", {RegWriteM, MemtoRegM, MemWriteM}, 3'b000);
        chk("rst_payload", {ALUOutM, WriteDataM, WriteRegM}, 69'h0);
        rst_n = 1'b1;
        #1 chk("rel_ReadyE_before_edge", ReadyE, 1'b0);
        @(posedge clk); #1;
        chk("rel_ReadyE_after_edge", ReadyE, 1'b1);
        sb.delete();
        mon_en = 1'b1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            FlushM = vecs[i].flush;
            ValidE = vecs[i].ve;
            ReadyM = vecs[i].rm;
            drive(vecs[i].alu, vecs[i].rw, vecs[i].mw);
            @(negedge clk);
            chk($sformatf("vec%0d_ValidM", i), ValidM, vecs[i].vm);
            chk($sformatf("vec%0d_ReadyE", i), ReadyE, vecs[i].re);
            chk($sformatf("vec%0d_ctrl", i), {RegWriteM, MemWriteM}, {vecs[i].rw_m, vecs[i].mw_m});
            if (vecs[i].vm)
                chk($sformatf("vec%0d_ALUOutM", i), ALUOutM, vecs[i].alu_m);
            @(posedge clk); #1;
        end
        FlushM = 1'b0;

        // Asynchronous reset in the middle of a held beat
        mon_en = 1'b0;
        ValidE = 1'b1; ReadyM = 1'b0;
        drive(32'h77, 1'b0, 1'b1);
        @(posedge clk); #1;
        ValidE = 1'b0;
        chk("arst_pre_ValidM", ValidM, 1'b1);
        chk("arst_pre_MemWriteM", MemWriteM, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ValidM", ValidM, 1'b0);
        chk("arst_MemWriteM", MemWriteM, 1'b0);
        chk("arst_ALUOutM", ALUOutM, 32'h0);
        chk("arst_ReadyE", ReadyE, 1'b0);
        #1 rst_n = 1'b1;
        #1 chk("arst_rel_ReadyE", ReadyE, 1'b0);
        @(posedge clk); #1;
        chk("arst_ReadyE_back", ReadyE, 1'b1);
        chk("arst_ValidM_after", ValidM, 1'b0);
        sb.delete();
        mon_en = 1'b1;

        // Random ValidE/ReadyM stream with incrementing payload
        @(posedge clk); #1;
        seq = 32'h100;
        pending = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (acc_flag) begin
                seq = seq + 32'd1;
                pending = 1'b0;
            end
            if (!pending) ValidE = ($urandom_range(0, 3) != 0);
            pending = ValidE;
            drive(seq, seq[0], seq[2]);
            ReadyM = ($urandom_range(0, 1) != 0);
            @(posedge clk); #1;
        end
        if (acc_flag) seq = seq + 32'd1;
        ValidE = 1'b0;
        ReadyM = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("beats_accepted_nonzero", (seq > 32'h180), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
